// File: rtl/exec_if.sv
// Execute-stage bus: ID-side instruction handshake, WB bypass, external ALU hookup
// and the EX/MEM output register. The master drives the stage, the slave is the stage.
interface exec_if #(
  parameter int XLEN     = 64,
  parameter int REG_BITS = 5
);
  logic                flush;
  logic                in_valid;
  logic                in_ready;
  logic [3:0]          in_alu_op;
  logic [REG_BITS-1:0] in_rd;
  logic [REG_BITS-1:0] in_rn;
  logic [REG_BITS-1:0] in_rm;
  logic [XLEN-1:0]     in_rn_val;
  logic [XLEN-1:0]     in_rm_val;
  logic [XLEN-1:0]     in_imm;
  logic                in_use_imm;
  logic                in_is_cbz;
  logic                in_reg_write;
  logic [XLEN-1:0]     in_pc;

  logic                wb_valid;
  logic [REG_BITS-1:0] wb_rd;
  logic [XLEN-1:0]     wb_data;

  logic [XLEN-1:0]     alu_a;
  logic [XLEN-1:0]     alu_b;
  logic [3:0]          alu_op;
  logic [XLEN-1:0]     alu_result;
  logic                alu_zero;

  logic                out_valid;
  logic                out_ready;
  logic [REG_BITS-1:0] out_rd;
  logic [XLEN-1:0]     out_result;
  logic                out_reg_write;
  logic                out_branch_taken;
  logic [XLEN-1:0]     out_branch_target;

  modport master (
    output flush, in_valid, in_alu_op, in_rd, in_rn, in_rm, in_rn_val, in_rm_val,
           in_imm, in_use_imm, in_is_cbz, in_reg_write, in_pc,
           wb_valid, wb_rd, wb_data, alu_result, alu_zero, out_ready,
    input  in_ready, alu_a, alu_b, alu_op,
           out_valid, out_rd, out_result, out_reg_write, out_branch_taken, out_branch_target
  );

  modport slave (
    input  flush, in_valid, in_alu_op, in_rd, in_rn, in_rm, in_rn_val, in_rm_val,
           in_imm, in_use_imm, in_is_cbz, in_reg_write, in_pc,
           wb_valid, wb_rd, wb_data, alu_result, alu_zero, out_ready,
    output in_ready, alu_a, alu_b, alu_op,
           out_valid, out_rd, out_result, out_reg_write, out_branch_taken, out_branch_target
  );
endinterface

// File: rtl/exec_stage.sv
// Execute stage: operand resolution, ALU drive and EX/MEM register with backpressure.
// Define EXEC_FWD_EN for EX/MEM and WB forwarding; otherwise dependent instructions stall.
module exec_stage #(
  parameter int XLEN     = 64,
  parameter int REG_BITS = 5
) (
  input logic   clk,
  input logic   rst_n,
  exec_if.slave bus
);
  localparam logic [REG_BITS-1:0] XZR     = '1;
  localparam logic [3:0]          OP_PASS = 4'b0111;

  logic [XLEN-1:0] rn_op;
  logic [XLEN-1:0] rm_op;
  logic            hazard;
  logic            transfer;
  logic            ex_rn, ex_rm, wb_rn, wb_rm;
  logic            rn_used, rm_used;

  assign ex_rn = bus.out_valid && bus.out_reg_write && (bus.out_rd == bus.in_rn);
  assign ex_rm = bus.out_valid && bus.out_reg_write && (bus.out_rd == bus.in_rm);
  // The XZR test ahead of these makes an explicit wb_rd != XZR check redundant.
  assign wb_rn = bus.wb_valid && (bus.wb_rd == bus.in_rn);
  assign wb_rm = bus.wb_valid && (bus.wb_rd == bus.in_rm);

  // CBZ ignores Rn (alu_a is forced to 0); Rm is read unless the immediate replaces it.
  assign rn_used = !bus.in_is_cbz;
  assign rm_used = bus.in_is_cbz || !bus.in_use_imm;

`ifdef EXEC_FWD_EN
  // NOTE: every output of a combinational block gets a default first so no path infers a latch.
  always_comb begin
    rn_op = bus.in_rn_val;
    if (bus.in_rn == XZR)  rn_op = '0;
    else if (ex_rn)        rn_op = bus.out_result;
    else if (wb_rn)        rn_op = bus.wb_data;

    rm_op = bus.in_rm_val;
    if (bus.in_rm == XZR)  rm_op = '0;
    else if (ex_rm)        rm_op = bus.out_result;
    else if (wb_rm)        rm_op = bus.wb_data;
  end

  assign hazard = 1'b0;
`else
  assign rn_op = (bus.in_rn == XZR) ? '0 : bus.in_rn_val;
  assign rm_op = (bus.in_rm == XZR) ? '0 : bus.in_rm_val;

  // Without bypass paths, hold the instruction until its producers have retired.
  assign hazard = (rn_used && (bus.in_rn != XZR) && (ex_rn || wb_rn)) ||
                  (rm_used && (bus.in_rm != XZR) && (ex_rm || wb_rm));
`endif

  always_comb begin
    bus.alu_a  = rn_op;
    bus.alu_b  = bus.in_use_imm ? bus.in_imm : rm_op;
    bus.alu_op = bus.in_alu_op;
    if (bus.in_is_cbz) begin
      bus.alu_a  = '0;
      bus.alu_b  = rm_op;
      bus.alu_op = OP_PASS;
    end
  end

  assign bus.in_ready = (!bus.out_valid || bus.out_ready) && !hazard;
  assign transfer     = bus.in_valid && bus.in_ready && !bus.flush;

  // NOTE: sequential state is updated with non-blocking assignments only, so every
  // register samples pre-edge values regardless of block evaluation order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.out_valid         <= 1'b0;
      bus.out_rd            <= '0;
      bus.out_result        <= '0;
      bus.out_reg_write     <= 1'b0;
      bus.out_branch_taken  <= 1'b0;
      bus.out_branch_target <= '0;
    end else if (bus.flush) begin
      bus.out_valid <= 1'b0;
    end else if (transfer) begin
      bus.out_valid         <= 1'b1;
      bus.out_rd            <= bus.in_rd;
      bus.out_result        <= bus.alu_result;
      bus.out_reg_write     <= bus.in_reg_write && !bus.in_is_cbz && (bus.in_rd != XZR);
      bus.out_branch_taken  <= bus.in_is_cbz && bus.alu_zero;
      bus.out_branch_target <= bus.in_pc + bus.in_imm;
    end else if (bus.out_ready) begin
      bus.out_valid <= 1'b0;
    end
  end
endmodule

// File: tb/tb_exec_stage.sv
// Directed-vector bench for exec_stage: stimulus pushes hand-computed expectations into a
// scoreboard queue, an independent monitor pops and compares on every EX/MEM handshake.
module tb_exec_stage;
  localparam int XLEN     = 64;
  localparam int REG_BITS = 5;
  localparam int BUDGET   = 50;

  localparam logic [3:0] OP_AND = 4'b0000;
  localparam logic [3:0] OP_ORR = 4'b0001;
  localparam logic [3:0] OP_ADD = 4'b0010;
  localparam logic [3:0] OP_SUB = 4'b0110;
  localparam logic [3:0] OP_CBZ = 4'b0111;

`ifdef EXEC_FWD_EN
  localparam int DEP_STALL = 0;
`else
  localparam int DEP_STALL = 1;
`endif

  typedef struct {
    logic [3:0]  op;
    logic [4:0]  rd, rn, rm;
    logic [63:0] rn_val, rm_val, imm;
    logic        use_imm, cbz, rw;
    logic [63:0] pc;
  } instr_t;

  typedef struct {
    logic [4:0]  rd;
    logic [63:0] result;
    logic        rw, taken;
    logic [63:0] target;
  } exp_t;

  logic clk;
  logic rst_n;
  int   vectors;
  int   miscompares;
  exp_t sb[$];

  exec_if #(.XLEN(XLEN), .REG_BITS(REG_BITS)) bus ();

  exec_stage #(.XLEN(XLEN), .REG_BITS(REG_BITS)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural model of the external 64-bit ALU.
  always_comb begin
    bus.alu_result = '0;
    case (bus.alu_op)
      OP_AND:  bus.alu_result = bus.alu_a & bus.alu_b;
      OP_ORR:  bus.alu_result = bus.alu_a | bus.alu_b;
      OP_ADD:  bus.alu_result = bus.alu_a + bus.alu_b;
      OP_SUB:  bus.alu_result = bus.alu_a - bus.alu_b;
      OP_CBZ:  bus.alu_result = bus.alu_b;
      default: bus.alu_result = '0;
    endcase
    bus.alu_zero = (bus.alu_result == '0);
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive(input instr_t t);
    bus.in_alu_op    = t.op;
    bus.in_rd        = t.rd;
    bus.in_rn        = t.rn;
    bus.in_rm        = t.rm;
    bus.in_rn_val    = t.rn_val;
    bus.in_rm_val    = t.rm_val;
    bus.in_imm       = t.imm;
    bus.in_use_imm   = t.use_imm;
    bus.in_is_cbz    = t.cbz;
    bus.in_reg_write = t.rw;
    bus.in_pc        = t.pc;
  endtask

  // Present one instruction until accepted; waits = cycles spent with in_ready low.
  task automatic issue(input instr_t t, input logic push, input exp_t e, output int waits);
    logic accepted;
    accepted = 1'b0;
    waits    = 0;
    @(negedge clk);
    drive(t);
    bus.in_valid = 1'b1;
    while (!accepted && waits <= BUDGET) begin
      #1;
      if (bus.in_ready) accepted = 1'b1;
      else begin
        waits++;
        @(negedge clk);
      end
    end
    check("accepted", {63'b0, accepted}, 64'd1);
    if (accepted && push) sb.push_back(e);
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < BUDGET) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    check("drained", 64'(sb.size()), 64'd0);
  endtask

  // Monitor: one scoreboard pop per output handshake.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (rst_n && bus.out_valid && bus.out_ready) begin
        if (sb.size() == 0) begin
          check("sb_has_entry", 64'd0, 64'd1);
        end else begin
          e = sb.pop_front();
          check("out_rd",            64'(bus.out_rd),           64'(e.rd));
          check("out_result",        bus.out_result,            e.result);
          check("out_reg_write",     64'(bus.out_reg_write),    64'(e.rw));
          check("out_branch_taken",  64'(bus.out_branch_taken), 64'(e.taken));
          check("out_branch_target", bus.out_branch_target,     e.target);
        end
      end
    end
  end

  initial begin
    int w;
    vectors       = 0;
    miscompares   = 0;
    rst_n         = 1'b0;
    bus.flush     = 1'b0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    bus.wb_valid  = 1'b0;
    bus.wb_rd     = '0;
    bus.wb_data   = '0;
    drive('{OP_AND, 5'd0, 5'd0, 5'd0, 64'd0, 64'd0, 64'd0, 1'b0, 1'b0, 1'b0, 64'd0});

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    #1;
    check("rst_out_valid",  64'(bus.out_valid),        64'd0);
    check("rst_out_rd",     64'(bus.out_rd),           64'd0);
    check("rst_out_result", bus.out_result,            64'd0);
    check("rst_out_rw",     64'(bus.out_reg_write),    64'd0);
    check("rst_out_taken",  64'(bus.out_branch_taken), 64'd0);
    check("rst_out_target", bus.out_branch_target,     64'd0);
    check("rst_in_ready",   64'(bus.in_ready),         64'd1);
    rst_n = 1'b1;

    // Back-to-back dependency: ADD X1 = 5 + 3, then SUB X2 = X1 - X1 with stale reads
    issue('{OP_ADD, 5'd1, 5'd2, 5'd3, 64'd5, 64'd3, 64'd0, 1'b0, 1'b0, 1'b1, 64'h100}, 1'b1,
          '{5'd1, 64'd8, 1'b1, 1'b0, 64'h100}, w);
    check("add_stall", 64'(w), 64'd0);
    issue('{OP_SUB, 5'd2, 5'd1, 5'd1, 64'd0, 64'd0, 64'd0, 1'b0, 1'b0, 1'b1, 64'h104}, 1'b1,
          '{5'd2, 64'd0, 1'b1, 1'b0, 64'h104}, w);
    check("dep_stall", 64'(w), 64'(DEP_STALL));

    // CBZ taken and not taken
    issue('{OP_ADD, 5'd7, 5'd31, 5'd5, 64'd0, 64'd0, 64'h20, 1'b0, 1'b1, 1'b1, 64'h1000}, 1'b1,
          '{5'd7, 64'd0, 1'b0, 1'b1, 64'h1020}, w);
    issue('{OP_ADD, 5'd7, 5'd31, 5'd6, 64'd0, 64'd42, 64'hFFFF_FFFF_FFFF_FFF8, 1'b0, 1'b1, 1'b0,
            64'h2000}, 1'b1, '{5'd7, 64'd42, 1'b0, 1'b0, 64'h1FF8}, w);
    wait_drain();

    // Backpressure: ORR held 4 cycles, then AND behind it, drained in order
    @(negedge clk);
    bus.out_ready = 1'b0;
    issue('{OP_ORR, 5'd3, 5'd8, 5'd9, 64'hF0F0, 64'h0F0F, 64'd0, 1'b0, 1'b0, 1'b1, 64'h3000}, 1'b1,
          '{5'd3, 64'hFFFF, 1'b1, 1'b0, 64'h3000}, w);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      #1;
      check("bp_out_valid", 64'(bus.out_valid), 64'd1);
      check("bp_hold",      bus.out_result,     64'hFFFF);
      check("bp_in_ready",  64'(bus.in_ready),  64'd0);
    end
    @(negedge clk);
    bus.out_ready = 1'b1;
    issue('{OP_AND, 5'd4, 5'd10, 5'd11, 64'hFF00FF, 64'h0FF0F0, 64'd0, 1'b0, 1'b0, 1'b1, 64'h3004},
          1'b1, '{5'd4, 64'h0F00F0, 1'b1, 1'b0, 64'h3004}, w);

    // XZR as source, XZR as destination, and no forwarding out of an rd = 31 write
    issue('{OP_ADD, 5'd5, 5'd31, 5'd0, 64'hDEAD, 64'd0, 64'd7, 1'b1, 1'b0, 1'b1, 64'h4000}, 1'b1,
          '{5'd5, 64'd7, 1'b1, 1'b0, 64'h4007}, w);
    issue('{OP_ADD, 5'd31, 5'd12, 5'd0, 64'd100, 64'd0, 64'd1, 1'b1, 1'b0, 1'b1, 64'h5000}, 1'b1,
          '{5'd31, 64'd101, 1'b0, 1'b0, 64'h5001}, w);
    issue('{OP_ORR, 5'd6, 5'd31, 5'd31, 64'h55, 64'h66, 64'd0, 1'b0, 1'b0, 1'b1, 64'h5004}, 1'b1,
          '{5'd6, 64'd0, 1'b1, 1'b0, 64'h5004}, w);
    wait_drain();

    // Flush kills a held output, then flush concurrent with a valid input drops it
    @(negedge clk);
    bus.out_ready = 1'b0;
    issue('{OP_ADD, 5'd8, 5'd13, 5'd14, 64'd1, 64'd2, 64'd0, 1'b0, 1'b0, 1'b1, 64'h7000}, 1'b0,
          '{5'd0, 64'd0, 1'b0, 1'b0, 64'd0}, w);
    @(negedge clk);
    bus.flush = 1'b1;
    @(posedge clk);
    #1;
    check("flush_kills_held", 64'(bus.out_valid), 64'd0);
    @(negedge clk);
    bus.out_ready = 1'b1;
    drive('{OP_ADD, 5'd9, 5'd13, 5'd14, 64'd4, 64'd5, 64'd0, 1'b0, 1'b0, 1'b1, 64'h7004});
    bus.in_valid = 1'b1;
    @(posedge clk);
    #1;
    check("flush_drops_input", 64'(bus.out_valid), 64'd0);
    bus.flush    = 1'b0;
    bus.in_valid = 1'b0;
    @(negedge clk);
    #1;
    check("flush_stays_empty", 64'(bus.out_valid), 64'd0);

    // Async reset during backpressure clears immediately
    bus.out_ready = 1'b0;
    issue('{OP_ADD, 5'd10, 5'd13, 5'd14, 64'd6, 64'd7, 64'd0, 1'b0, 1'b0, 1'b1, 64'h8000}, 1'b0,
          '{5'd0, 64'd0, 1'b0, 1'b0, 64'd0}, w);
    @(negedge clk);
    #1;
    check("pre_rst_valid", 64'(bus.out_valid), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_valid",  64'(bus.out_valid),  64'd0);
    check("async_rst_result", bus.out_result,      64'd0);
    check("async_rst_rd",     64'(bus.out_rd),     64'd0);
    @(negedge clk);
    rst_n         = 1'b1;
    bus.out_ready = 1'b1;

    // Recovery after reset
    issue('{OP_ADD, 5'd1, 5'd13, 5'd14, 64'd10, 64'd20, 64'd0, 1'b0, 1'b0, 1'b1, 64'h6000}, 1'b1,
          '{5'd1, 64'd30, 1'b1, 1'b0, 64'h6000}, w);
    wait_drain();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/exec_stage.md
Name: exec_stage

Overview:
- Execute stage wrapped around the 64-bit `alu` (ops: 0000 AND, 0001 ORR, 0010 ADD, 0110 SUB, 0111 CBZ/pass).
- Takes one decoded instruction per valid/ready handshake from ID and resolves operands: XZR, EX/MEM forwarding, WB forwarding, immediate select.
- Drives the ALU combinationally and captures result, zero flag and CBZ branch decision into a single EX/MEM output register with backpressure.

Parameters:
- XLEN, 64, datapath width (ALU is 64-bit; only 64 supported).
- REG_BITS, 5, register index width; index 31 = XZR.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- flush  in  1  kill: drops the incoming instruction and invalidates the output register.
- in_valid  in  1  ID presents an instruction.
- in_ready  out  1  stage accepts this cycle.
- in_alu_op  in  4  ALU operation code.
- in_rd, in_rn, in_rm  in  REG_BITS  destination / source indices (rm = Rt for CBZ).
- in_rn_val, in_rm_val  in  XLEN  register-file read data.
- in_imm  in  XLEN  sign-extended immediate / branch byte offset.
- in_use_imm  in  1  ALU B = imm instead of rm operand.
- in_is_cbz  in  1  instruction is CBZ.
- in_reg_write  in  1  instruction writes rd.
- in_pc  in  XLEN  instruction PC.
- wb_valid  in  1  WB stage writing this cycle.
- wb_rd  in  REG_BITS  WB destination.
- wb_data  in  XLEN  WB data.
- alu_a, alu_b  out  XLEN  ALU operands (combinational).
- alu_op  out  4  ALU op (combinational).
- alu_result  in  XLEN  ALU result.
- alu_zero  in  1  ALU zero flag.
- out_valid  out  1  EX/MEM register holds an instruction.
- out_ready  in  1  MEM accepts.
- out_rd  out  REG_BITS  registered destination.
- out_result  out  XLEN  registered ALU result.
- out_reg_write  out  1  registered write enable; forced 0 for CBZ.
- out_branch_taken  out  1  registered: CBZ with Rt == 0.
- out_branch_target  out  XLEN  registered in_pc + in_imm, modulo 2^64.

Behaviour:
- Reset: every output register is 0 (out_valid, out_rd, out_result, out_reg_write, out_branch_taken, out_branch_target).
- Handshake:
  - in_ready = !out_valid || out_ready. Without EXEC_FWD_EN it is additionally gated by the hazard term.
  - Transfer occurs when in_valid && in_ready && !flush. On transfer the output register loads on the next edge; latency is 1 cycle.
  - If out_valid && out_ready and there is no transfer, out_valid clears.
  - If out_valid && !out_ready, all output registers hold.
- Operand resolution, per source, highest priority first:
  1. Index 31 gives 0.
  2. out_valid && out_reg_write && out_rd == idx gives out_result.
  3. wb_valid && wb_rd == idx && wb_rd != 31 gives wb_data.
  4. Otherwise in_*_val.
- ALU drive:
  - Normal: alu_a = op(rn); alu_b = in_use_imm ? in_imm : op(rm); alu_op = in_alu_op.
  - CBZ: alu_a = 0, alu_b = op(rm), alu_op = 0111. branch_taken = alu_zero.
- out_reg_write = in_reg_write && !in_is_cbz && in_rd != 31.
- flush:
  - Synchronous; wins over everything. On the next edge out_valid = 0 and any concurrent input is dropped.
  - in_ready may be 1 during flush, but no transfer counts.
- Reset asserted mid-operation: immediate clear, no partial capture.

Optional Feature:
- EXEC_FWD_EN.
  - Defined: forwarding priorities 2 and 3 are active; no hazard stalls.
  - Undefined: priorities 2 and 3 are removed. hazard = any non-XZR source used by the instruction matches (out_valid && out_reg_write && out_rd) or (wb_valid && wb_rd). While hazard is set, in_ready = 0.
  - Functional results are identical either way; only cycle counts differ.

Test Plan:
- Reset: hold rst_n=0 for 3 cycles -> all outputs 0, in_ready=1.
- Back-to-back dependency: ADD X1 = 5+3, then SUB X2 = X1 - X1 with stale rm/rn_val = 0.
  - Defined: second result 0 one cycle later.
  - Undefined: 1 stall cycle, same result.
- CBZ:
  - Rt = 0, pc = 0x1000, imm = 0x20 -> out_branch_taken = 1, target = 0x1020, out_reg_write = 0.
  - Rt = 42 -> taken = 0.
- Backpressure: out_ready = 0 for 4 cycles with ORR 0xF0F0|0x0F0F pending -> out_result holds 0xFFFF, in_ready = 0, then drains in order.
- XZR: rn = 31, in_rn_val = 0xDEAD, ADD imm 7 -> result 7. Also rd = 31 -> out_reg_write = 0 and no forwarding from it.
- Flush concurrent with in_valid -> out_valid = 0 next cycle, instruction discarded. Separately, async reset mid-backpressure -> out_valid drops immediately.
